// File: rtl/wb_pkg.sv
// Shared widths and the pending-writeback entry type for the writeback buffer.
// Types only; carries no state, adds no latency and applies no backpressure.
package wb_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the valid window [head, head+count) of the buffer.
// Purely combinational (0 cycles); never backpressures.
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  wb_entry_t [DEPTH-1:0]  entries,
  input  logic [PW-1:0]          head,
  input  logic [CW-1:0]          count,
  input  logic [REG_ADDR_W-1:0]  addr,
  output logic                   hit,
  output logic [XLEN-1:0]        data
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match seen wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (addr != '0) && (entries[idx].rd == addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_buffer.sv
// Circular writeback buffer draining into the register file, with two forwarding ports.
// Empty-to-rf_write latency 1 cycle; in_ready drops only when full, independent of rf_ready.
module wb_buffer
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]       in_data,
  input  logic                  rf_ready,
  output logic                  rf_write,
  output logic [REG_ADDR_W-1:0] rf_wr_addr,
  output logic [XLEN-1:0]       rf_wr_data,
  input  logic [REG_ADDR_W-1:0] fwd_addr_01,
  input  logic [REG_ADDR_W-1:0] fwd_addr_02,
  output logic                  fwd_hit_01,
  output logic                  fwd_hit_02,
  output logic [XLEN-1:0]       fwd_data_01,
  output logic [XLEN-1:0]       fwd_data_02,
  output logic [CW-1:0]         count
);

  wb_entry_t [DEPTH-1:0] entries;
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic                  push;
  logic                  pop;

  assign in_ready   = (count != CW'(DEPTH));
  assign rf_write   = (count != '0);
  assign rf_wr_addr = rf_write ? entries[head].rd   : '0;
  assign rf_wr_data = rf_write ? entries[head].data : '0;

  // Writes to x0 are acknowledged but dropped.
  assign push = in_valid && in_ready && (in_rd != '0);
  assign pop  = rf_write && rf_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      entries <= '0;
    end else begin
      if (push) begin
        entries[tail] <= '{rd: in_rd, data: in_data};
        tail          <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_01 (
    .entries (entries),
    .head    (head),
    .count   (count),
    .addr    (fwd_addr_01),
    .hit     (fwd_hit_01),
    .data    (fwd_data_01)
  );

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_02 (
    .entries (entries),
    .head    (head),
    .count   (count),
    .addr    (fwd_addr_02),
    .hit     (fwd_hit_02),
    .data    (fwd_data_02)
  );

endmodule

// File: tb/tb_wb_buffer.sv
// Bench for wb_buffer: queue-based reference model, per-cycle compare, directed pins plus random traffic.
module tb_wb_buffer;
  import wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                  clock;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] in_rd;
  logic [XLEN-1:0]       in_data;
  logic                  rf_ready;
  logic                  rf_write;
  logic [REG_ADDR_W-1:0] rf_wr_addr;
  logic [XLEN-1:0]       rf_wr_data;
  logic [REG_ADDR_W-1:0] fwd_addr_01;
  logic [REG_ADDR_W-1:0] fwd_addr_02;
  logic                  fwd_hit_01;
  logic                  fwd_hit_02;
  logic [XLEN-1:0]       fwd_data_01;
  logic [XLEN-1:0]       fwd_data_02;
  logic [CW-1:0]         count;

  wb_buffer #(.DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rd       (in_rd),
    .in_data     (in_data),
    .rf_ready    (rf_ready),
    .rf_write    (rf_write),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .fwd_addr_01 (fwd_addr_01),
    .fwd_addr_02 (fwd_addr_02),
    .fwd_hit_01  (fwd_hit_01),
    .fwd_hit_02  (fwd_hit_02),
    .fwd_data_01 (fwd_data_01),
    .fwd_data_02 (fwd_data_02),
    .count       (count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending writes in arrival order, oldest at index 0.
  wb_entry_t q[$];
  bit        m_push;
  bit        m_pop;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      q.delete();
    end else begin
      m_push = in_valid && (q.size() < DEPTH) && (in_rd != 0);
      m_pop  = (q.size() != 0) && rf_ready;
      if (m_pop)  void'(q.pop_front());
      if (m_push) q.push_back('{rd: in_rd, data: in_data});
    end
  end

  function automatic logic [XLEN:0] fwd_exp(input logic [REG_ADDR_W-1:0] a);
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (a != 0 && q[i].rd == a) return {1'b1, q[i].data};
    end
    return '0;
  endfunction

  // Literal expectations posted by the driver for the next falling edge.
  // 0 count, 1 in_ready, 2 rf_write, 3 rf_wr_data, 4 fwd_hit_01, 5 fwd_data_01
  logic [5:0]  pin_en = '0;
  logic [31:0] pin_val[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  logic [XLEN:0] e1, e2;
  always @(negedge clock) begin
    e1 = fwd_exp(fwd_addr_01);
    e2 = fwd_exp(fwd_addr_02);
    chk("count",       32'(count),       32'(q.size()));
    chk("in_ready",    32'(in_ready),    32'(q.size() != DEPTH));
    chk("rf_write",    32'(rf_write),    32'(q.size() != 0));
    chk("rf_wr_addr",  32'(rf_wr_addr),  (q.size() != 0) ? 32'(q[0].rd) : 32'd0);
    chk("rf_wr_data",  rf_wr_data,       (q.size() != 0) ? q[0].data : 32'd0);
    chk("fwd_hit_01",  32'(fwd_hit_01),  32'(e1[XLEN]));
    chk("fwd_data_01", fwd_data_01,      e1[XLEN-1:0]);
    chk("fwd_hit_02",  32'(fwd_hit_02),  32'(e2[XLEN]));
    chk("fwd_data_02", fwd_data_02,      e2[XLEN-1:0]);
    if (pin_en[0]) chk("pin_count",       32'(count),      pin_val[0]);
    if (pin_en[1]) chk("pin_in_ready",    32'(in_ready),   pin_val[1]);
    if (pin_en[2]) chk("pin_rf_write",    32'(rf_write),   pin_val[2]);
    if (pin_en[3]) chk("pin_rf_wr_data",  rf_wr_data,      pin_val[3]);
    if (pin_en[4]) chk("pin_fwd_hit_01",  32'(fwd_hit_01), pin_val[4]);
    if (pin_en[5]) chk("pin_fwd_data_01", fwd_data_01,     pin_val[5]);
  end

  task automatic step();
    @(posedge clock);
    #1;
    pin_en = '0;
  endtask

  task automatic pin(input int k, input logic [31:0] v);
    pin_en[k]  = 1'b1;
    pin_val[k] = v;
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_rd       = '0;
    in_data     = '0;
    rf_ready    = 1'b0;
    fwd_addr_01 = 5'd5;
    fwd_addr_02 = 5'd0;
    #2 reset = 1'b0;

    // Held in reset, then released with idle inputs.
    step(); pin(0, 0); pin(1, 1); pin(2, 0); pin(4, 0); pin(5, 0);
    step(); reset = 1'b1; pin(0, 0); pin(1, 1); pin(2, 0); pin(4, 0);

    // Two writes to the same rd; youngest forwards, both drain in order.
    step(); in_valid = 1'b1; in_rd = 5'd5; in_data = 32'hA;
    step(); in_data = 32'hB; pin(0, 1);
    step(); in_valid = 1'b0;
            pin(0, 2); pin(4, 1); pin(5, 32'hB); pin(2, 1); pin(3, 32'hA);
    step(); rf_ready = 1'b1; pin(0, 2); pin(3, 32'hA); pin(5, 32'hB);
    step(); pin(0, 1); pin(3, 32'hB); pin(4, 1); pin(5, 32'hB);
    step(); rf_ready = 1'b0; pin(0, 0); pin(2, 0); pin(4, 0); pin(5, 0);

    // Fill to DEPTH, hold a fifth offer, one pop reopens in_ready next cycle.
    for (int k = 0; k < DEPTH; k++) begin
      step(); in_valid = 1'b1; in_rd = 5'(k + 1); in_data = 32'(k + 'h10);
    end
    step(); in_rd = 5'd7; in_data = 32'h55; pin(0, 4); pin(1, 0);
    step(); pin(0, 4); pin(1, 0);
    step(); rf_ready = 1'b1; pin(0, 4); pin(1, 0);
    step(); rf_ready = 1'b0; pin(0, 3); pin(1, 1);
    step(); in_valid = 1'b0; pin(0, 4); pin(3, 32'h11);
    step(); rf_ready = 1'b1;
    repeat (5) step();
    rf_ready = 1'b0; pin(0, 0);

    // Writes to x0 handshake but never enqueue or forward.
    fwd_addr_01 = 5'd0;
    step(); in_valid = 1'b1; in_rd = 5'd0; in_data = 32'hFF; pin(1, 1);
    step(); in_valid = 1'b0; pin(0, 0); pin(2, 0); pin(4, 0); pin(5, 0);

    // Streaming: one write per cycle, count steady at 1 through pointer wrap.
    step(); in_valid = 1'b1; rf_ready = 1'b1;
    in_rd = 5'($urandom_range(1, 31)); in_data = $urandom;
    for (int k = 0; k < 20; k++) begin
      step(); in_rd = 5'($urandom_range(1, 31)); in_data = $urandom;
      fwd_addr_01 = in_rd; pin(0, 1); pin(2, 1);
    end
    step(); in_valid = 1'b0; pin(0, 1);
    step(); rf_ready = 1'b0; pin(0, 0);

    // Reset in the middle of draining three entries.
    for (int k = 0; k < 3; k++) begin
      step(); in_valid = 1'b1; in_rd = 5'd9; in_data = 32'(k + 1);
    end
    step(); in_valid = 1'b0; rf_ready = 1'b1; pin(0, 3);
    step(); reset = 1'b0; pin(0, 0); pin(2, 0); pin(3, 0);
    step(); reset = 1'b1; rf_ready = 1'b0; pin(0, 0); pin(2, 0);

    // Random traffic with a narrow rd range to force duplicates and x0 writes.
    for (int k = 0; k < 3000; k++) begin
      step();
      in_valid    = ($urandom_range(0, 9) < 7);
      in_rd       = 5'($urandom_range(0, 7));
      in_data     = $urandom;
      rf_ready    = ($urandom_range(0, 1) == 1);
      fwd_addr_01 = 5'($urandom_range(0, 7));
      fwd_addr_02 = 5'($urandom_range(0, 7));
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 299) == 0) reset = 1'b0;
    end
    step(); reset = 1'b1; in_valid = 1'b0; rf_ready = 1'b1;
    repeat (DEPTH + 2) step();
    rf_ready = 1'b0; pin(0, 0); pin(2, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_buffer.md
WB_BUFFER -- requirements
Module: wb_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of pending-write entries; SHALL be a power of two, 2..16.
REQ-002 clock  input  1  single clock; all state SHALL update on posedge clock.
REQ-003 reset  input  1  asynchronous, active-low reset; asserts immediately, releases synchronously to clock.
REQ-004 in_valid  input  1  producer offers a writeback result.
REQ-005 in_ready  output  1  buffer can accept a result this cycle.
REQ-006 in_rd  input  5  destination register address.
REQ-007 in_data  input  32  result data.
REQ-008 rf_ready  input  1  register-file write port available this cycle.
REQ-009 rf_write  output  1  write enable to the register file.
REQ-010 rf_wr_addr  output  5  register-file write address (rd).
REQ-011 rf_wr_data  output  32  register-file write data.
REQ-012 fwd_addr_01 / fwd_addr_02  input  5 each  rs1 / rs2 lookup addresses.
REQ-013 fwd_hit_01 / fwd_hit_02  output  1 each  pending write exists for that address.
REQ-014 fwd_data_01 / fwd_data_02  output  32 each  youngest pending data for that address.
REQ-015 count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-016 Storage SHALL be a circular FIFO of {rd, data} entries, with head/tail pointers wrapping modulo DEPTH.
REQ-017 Handshake: transfer occurs at a posedge where in_valid && in_ready are both high; in_ready SHALL equal (count != DEPTH) and SHALL NOT depend on in_valid or rf_ready.
REQ-018 Transfer with in_rd == 0 SHALL complete the handshake but SHALL NOT enqueue; count is unchanged by it.
REQ-019 rf_write SHALL equal (count != 0); rf_wr_addr/rf_wr_data SHALL be the head entry when count != 0, else 0/0.
REQ-020 Dequeue: the head pops at a posedge where rf_write && rf_ready; an entry is presented for at least one full cycle, so the register file's negedge write samples stable values.
REQ-021 Simultaneous enqueue and dequeue SHALL leave count unchanged; at full, a simultaneous dequeue SHALL NOT open in_ready in the same cycle.
REQ-022 Latency: an accepted entry into an empty buffer drives rf_write in the next cycle (1 cycle).
REQ-023 Forwarding is combinational over valid entries only: hit when some entry has rd == fwd_addr and fwd_addr != 0; data is taken from the youngest matching entry; no hit gives data 0.
REQ-024 The head entry stays forwardable in the cycle it is being written, with no gap between the buffer and register-file visibility.
REQ-025 Multiple pending writes to the same rd SHALL all drain in arrival order; there is no coalescing.
REQ-026 count SHALL never exceed DEPTH nor underflow; rf_ready while empty has no effect.

Reset
REQ-027 On reset low: head, tail and count SHALL be 0 and all entries cleared to 0.
REQ-028 During reset: rf_write=0, rf_wr_addr=0, rf_wr_data=0, fwd_hit_*=0, fwd_data_*=0, in_ready=1.
REQ-029 Reset mid-drain SHALL discard all pending entries, with no partial writes after assertion.

Structure
REQ-030 Package wb_pkg SHALL hold XLEN=32, REG_ADDR_W=5, and typedef wb_entry_t {rd, data}.
REQ-031 One sub-module, wb_fwd_match (youngest-match priority search over entries given head/count), SHALL be instantiated twice, once per lookup port.

Verification
REQ-032 Reset low, then release with idle inputs -> count=0, rf_write=0, in_ready=1, fwd_hit_*=0.
REQ-033 Enqueue rd=5/0xA, rd=5/0xB with rf_ready=0 -> count=2, fwd_addr_01=5 gives hit=1 and data=0xB; after rf_ready=1, writes appear in order 0xA then 0xB.
REQ-034 Fill DEPTH=4 with rf_ready=0 -> in_ready=0 at count=4; a fifth offer is held; one dequeue reopens in_ready the next cycle.
REQ-035 Enqueue rd=0/0xFF -> handshake completes, count stays 0, rf_write stays 0, fwd_addr=0 never hits.
REQ-036 Continuous in_valid and rf_ready=1 -> one write per cycle, count steady at 1, pointers wrap past DEPTH without loss or reordering.
REQ-037 Reset asserted with count=3 mid-drain -> rf_write=0 immediately; count=0 after release.
